// File: rtl/mult_fu_pkg.sv
// Shared types and helpers for the pipelined multiply unit.
// `MULT_STAGES sets the default pipeline depth (2, 4 or 8).
`ifndef MULT_STAGES
`define MULT_STAGES 4
`endif

package sys_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PRN_W = 6;
  localparam int unsigned DW    = 2 * XLEN;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } MULT_FUNC;

  typedef struct packed {
    logic             valid;
    MULT_FUNC         func;
    logic [PRN_W-1:0] dest_prn;
    logic [DW-1:0]    mcand;
    logic [DW-1:0]    mplier;
    logic [DW-1:0]    sum;
  } MULT_STAGE_PACKET;

  function automatic logic [DW-1:0] mult_ext(input logic [XLEN-1:0] v, input logic sgn);
    return {{XLEN{sgn & v[XLEN-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] mult_select(input MULT_FUNC f, input logic [DW-1:0] p);
    return (f == MUL) ? p[XLEN-1:0] : p[DW-1:XLEN];
  endfunction

endpackage

// File: rtl/mult_fu_if.sv
// Issue-side and CDB-side signals of the multiply unit.
interface mult_fu_if;
  import sys_defs::*;

  logic             issue_valid;
  logic [XLEN-1:0]  issue_rs1;
  logic [XLEN-1:0]  issue_rs2;
  logic [1:0]       issue_func;
  logic [PRN_W-1:0] issue_dest_prn;
  logic             mult_cdb_gnt;
  logic             mult_free;
  logic             mult_cdb_req;
  logic             out_valid;
  logic [XLEN-1:0]  out_result;
  logic [PRN_W-1:0] out_dest_prn;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_func, issue_dest_prn, mult_cdb_gnt,
    input  mult_free, mult_cdb_req, out_valid, out_result, out_dest_prn
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_func, issue_dest_prn, mult_cdb_gnt,
    output mult_free, mult_cdb_req, out_valid, out_result, out_dest_prn
  );
endinterface

// File: rtl/mult_stage.sv
// One combinational partial-product step: consume CH multiplier bits, shift for the next step.
module mult_stage
  import sys_defs::*;
#(
  parameter int unsigned CH = 16
) (
  input  MULT_STAGE_PACKET cur,
  output MULT_STAGE_PACKET nxt
);

  logic [DW-1:0] chunk;

  always_comb begin
    chunk       = DW'(cur.mplier[CH-1:0]);
    nxt         = cur;
    nxt.sum     = cur.sum + cur.mcand * chunk;
    nxt.mcand   = cur.mcand << CH;
    nxt.mplier  = cur.mplier >> CH;
  end

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit with CDB request/grant and squash.
// Define MULT_BUBBLE_COLLAPSE_EN to let stages behind a stalled head close up bubbles.
module mult_fu
  import sys_defs::*;
#(
  parameter int unsigned STAGES = `MULT_STAGES
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      squash,
  mult_fu_if.slave  bus
);

  localparam int unsigned CH   = DW / STAGES;
  localparam int unsigned LAST = STAGES - 2;  // stage that requests the CDB

  MULT_STAGE_PACKET pipe_q    [STAGES-1];
  MULT_STAGE_PACKET stage_in  [STAGES];
  MULT_STAGE_PACKET stage_out [STAGES];

  logic             out_valid_q;
  logic [XLEN-1:0]  out_result_q;
  logic [PRN_W-1:0] out_dest_q;

  logic             stall;
  logic             free;
  logic [LAST:0]    adv;
  MULT_FUNC         issue_fn;

  always_comb begin
    issue_fn             = MULT_FUNC'(bus.issue_func);
    stage_in[0]          = '0;
    stage_in[0].valid    = bus.issue_valid;
    stage_in[0].func     = issue_fn;
    stage_in[0].dest_prn = bus.issue_dest_prn;
    stage_in[0].mcand    = mult_ext(bus.issue_rs1, (issue_fn == MULH) || (issue_fn == MULHSU));
    stage_in[0].mplier   = mult_ext(bus.issue_rs2, issue_fn == MULH);
    for (int k = 1; k < int'(STAGES); k++) begin
      stage_in[k] = pipe_q[k-1];
    end
  end

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
    mult_stage #(.CH(CH)) u_stage (
      .cur (stage_in[g]),
      .nxt (stage_out[g])
    );
  end

  // adv[k]: contents of stage k move on at this edge
  always_comb begin
    stall     = pipe_q[LAST].valid && !bus.mult_cdb_gnt;
    adv       = '0;
    adv[LAST] = !stall;
`ifdef MULT_BUBBLE_COLLAPSE_EN
    for (int k = int'(STAGES) - 3; k >= 0; k--) begin
      adv[k] = !pipe_q[k+1].valid || adv[k+1];
    end
    free = !pipe_q[0].valid || adv[0];
`else
    adv  = {(LAST+1){!stall}};
    free = !stall;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        pipe_q[k] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_dest_q   <= '0;
    end else if (squash) begin
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        pipe_q[k].valid <= 1'b0;
      end
      out_valid_q <= 1'b0;
    end else begin
      if (free) begin
        pipe_q[0] <= stage_out[0];
      end
      for (int k = 1; k <= int'(LAST); k++) begin
        if (adv[k-1]) begin
          pipe_q[k] <= stage_out[k];
        end
      end
      out_valid_q <= pipe_q[LAST].valid && bus.mult_cdb_gnt;
      if (pipe_q[LAST].valid && bus.mult_cdb_gnt) begin
        out_result_q <= mult_select(stage_out[STAGES-1].func, stage_out[STAGES-1].sum);
        out_dest_q   <= stage_out[STAGES-1].dest_prn;
      end
    end
  end

  assign bus.mult_free    = free;
  assign bus.mult_cdb_req = pipe_q[LAST].valid && !squash;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_dest_prn = out_dest_q;

  logic unused_bits;
  assign unused_bits = ^{stage_out[STAGES-1].mcand, stage_out[STAGES-1].mplier, adv[LAST]};

endmodule

// File: tb/tb_mult_fu.sv
// Self-checking bench for mult_fu: directed scenarios plus random traffic vs a reference model.
module tb_mult_fu;
  import sys_defs::*;

  localparam int STAGES = 4;
`ifdef MULT_BUBBLE_COLLAPSE_EN
  localparam logic EXP_BUBBLE_FREE = 1'b1;
`else
  localparam logic EXP_BUBBLE_FREE = 1'b0;
`endif

  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic squash = 1'b0;

  mult_fu_if bus ();

  mult_fu #(.STAGES(STAGES)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  dest;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sbq[$];
  logic        tab_en;
  logic [31:0] tab_exp;
  logic [31:0] post_exp;

  logic [1:0]  t_f   [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
  logic [31:0] t_a   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] t_b   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h00000002};
  logic [31:0] t_exp [4] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};

  // Reference: full 64-bit product from signed/unsigned interpretation of the operands
  function automatic logic [31:0] ref_mult(input logic [1:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f)
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      default: return $urandom_range(0, 15);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] d);
    bus.issue_valid    = 1'b1;
    bus.issue_func     = f;
    bus.issue_rs1      = a;
    bus.issue_rs2      = b;
    bus.issue_dest_prn = d;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
  endtask

  // One clock: record accepted issue (or flush on squash), then score any broadcast.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    if (squash) begin
      sbq.delete();
    end else if (bus.issue_valid && bus.mult_free) begin
      e.res  = tab_en ? tab_exp
                      : ref_mult(bus.issue_func, bus.issue_rs1, bus.issue_rs2);
      e.dest = bus.issue_dest_prn;
      sbq.push_back(e);
    end
    @(posedge clock);
    #1;
    if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_result", 64'(bus.out_result), 64'(e.res));
        chk("sb_dest", 64'(bus.out_dest_prn), 64'(e.dest));
      end
    end
  endtask

  initial begin
    bus.issue_valid    = 1'b0;
    bus.issue_rs1      = '0;
    bus.issue_rs2      = '0;
    bus.issue_func     = '0;
    bus.issue_dest_prn = '0;
    bus.mult_cdb_gnt   = 1'b0;
    tab_en             = 1'b0;
    tab_exp            = '0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    chk("rst_out_dest", 64'(bus.out_dest_prn), 64'd0);
    chk("rst_req", 64'(bus.mult_cdb_req), 64'd0);
    chk("rst_free", 64'(bus.mult_free), 64'd1);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;

    // Single MUL 7*6 -> 42, tag 5; req three edges after issue, broadcast after four
    bus.mult_cdb_gnt = 1'b1;
    tab_en  = 1'b1;
    tab_exp = 32'd42;
    drive_op(2'd0, 32'd7, 32'd6, 6'd5);
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 1) idle();
      chk("single_req", 64'(bus.mult_cdb_req), 64'(i == 3));
      chk("single_valid", 64'(bus.out_valid), 64'(i == STAGES));
      if (i == STAGES) begin
        chk("single_result", 64'(bus.out_result), 64'd42);
        chk("single_dest", 64'(bus.out_dest_prn), 64'd5);
      end
    end

    // Function coverage with known answers
    for (int j = 0; j < 4; j++) begin
      tab_exp = t_exp[j];
      drive_op(t_f[j], t_a[j], t_b[j], 6'(20 + j));
      cycle();
    end
    idle();
    repeat (STAGES + 1) cycle();
    chk("func_drain", 64'(sbq.size()), 64'd0);
    tab_en = 1'b0;

    // Stall: four back-to-back ops, grant withheld for three cycles
    for (int i = 0; i < 4; i++) begin
      drive_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 6'(10 + i));
      cycle();
    end
    idle();
    bus.mult_cdb_gnt = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_free", 64'(bus.mult_free), 64'd0);
      chk("stall_req", 64'(bus.mult_cdb_req), 64'd1);
      cycle();
      chk("stall_no_out", 64'(bus.out_valid), 64'd0);
    end
    bus.mult_cdb_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_release_out", 64'(bus.out_valid), 64'd1);
    end
    cycle();
    chk("stall_tail_out", 64'(bus.out_valid), 64'd0);
    chk("stall_drain", 64'(sbq.size()), 64'd0);

    // Squash with ops in stages 0..2 plus same-cycle grant and issue
    for (int i = 0; i < 3; i++) begin
      drive_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 6'(40 + i));
      cycle();
    end
    drive_op(2'd0, 32'd3, 32'd3, 6'd50);
    squash = 1'b1;
    #1;
    chk("squash_req_masked", 64'(bus.mult_cdb_req), 64'd0);
    cycle();
    squash = 1'b0;
    idle();
    #1;
    chk("squash_req_after", 64'(bus.mult_cdb_req), 64'd0);
    chk("squash_free_after", 64'(bus.mult_free), 64'd1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("squash_no_out", 64'(bus.out_valid), 64'd0);
    end

    // Asynchronous reset between edges while a result is being broadcast
    for (int i = 0; i < 3; i++) begin
      drive_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 6'(60 + i));
      cycle();
    end
    idle();
    cycle();
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_result", 64'(bus.out_result), 64'd0);
    chk("arst_out_dest", 64'(bus.out_dest_prn), 64'd0);
    chk("arst_req", 64'(bus.mult_cdb_req), 64'd0);
    chk("arst_free", 64'(bus.mult_free), 64'd1);
    sbq.delete();
    reset = 1'b1;
    drive_op(2'd1, 32'hFFFF1234, 32'h00ABCDEF, 6'd33);
    post_exp = ref_mult(2'd1, 32'hFFFF1234, 32'h00ABCDEF);
    for (int i = 1; i <= STAGES + 1; i++) begin
      cycle();
      if (i == 1) idle();
      chk("post_rst_valid", 64'(bus.out_valid), 64'(i == STAGES));
      if (i == STAGES) chk("post_rst_result", 64'(bus.out_result), 64'(post_exp));
    end

    // Ops in stages 0 and 2 only, grant low: bubble behaviour
    drive_op(2'd3, rand_operand(), rand_operand(), 6'd1);
    cycle();
    idle();
    cycle();
    drive_op(2'd0, rand_operand(), rand_operand(), 6'd2);
    cycle();
    idle();
    bus.mult_cdb_gnt = 1'b0;
    #1;
    chk("bubble_free", 64'(bus.mult_free), 64'(EXP_BUBBLE_FREE));
    cycle();
    bus.mult_cdb_gnt = 1'b1;
    repeat (6) cycle();
    chk("bubble_drain", 64'(sbq.size()), 64'd0);

    // Random traffic with stalls and occasional squash
    for (int n = 0; n < 600; n++) begin
      bus.mult_cdb_gnt = ($urandom_range(0, 3) != 0);
      squash           = ($urandom_range(0, 49) == 0);
      #1;
      if (bus.mult_free && ($urandom_range(0, 2) != 0))
        drive_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 6'($urandom));
      else
        idle();
      cycle();
    end
    squash = 1'b0;
    bus.mult_cdb_gnt = 1'b1;
    idle();
    repeat (8) cycle();
    chk("rand_drain", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Pipelined integer multiply functional unit in the execute stage, directly downstream of Issue.
- Accepts one issued RV32M multiply per cycle, which Issue gates on mult_free.
- Raises mult_cdb_req one cycle before its result is ready and broadcasts only on mult_cdb_gnt; otherwise the pipeline stalls, which drops mult_free.
- Flushes all in-flight work on squash.

Parameters:
- XLEN, 32, operand and result width.
- STAGES, 4, pipeline depth; legal values 2, 4, 8. Each stage consumes 2*XLEN/STAGES multiplier bits.
- PRN_W, 6, physical register tag width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  Issue presents a multiply this cycle
- issue_rs1  in  XLEN  source 1 data from regfile
- issue_rs2  in  XLEN  source 2 data from regfile
- issue_func  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
- issue_dest_prn  in  PRN_W  destination physical register
- squash  in  1  mispredict flush
- mult_cdb_gnt  in  1  CDB arbiter grant for this FU
- mult_free  out  1  combinational; an issue is accepted this cycle
- mult_cdb_req  out  1  combinational; stage STAGES-2 holds a live op
- out_valid  out  1  result broadcast, one-cycle pulse
- out_result  out  XLEN  broadcast data
- out_dest_prn  out  PRN_W  broadcast tag

Behaviour:
- Reset (reset==0, async): all stage valid bits, out_valid, out_result and out_dest_prn go to 0. Consequently mult_cdb_req=0 and mult_free=1.
- Operand extension to 2*XLEN bits:
  - rs1 sign-extended for MULH and MULHSU, else zero-extended.
  - rs2 sign-extended for MULH only.
  - Product is taken mod 2^(2*XLEN).
- Stage k registers: valid, func, dest_prn, multiplicand shifted left by k*CH, remaining multiplier bits, and accumulated partial sum. CH = 2*XLEN/STAGES.
- Result selection: MUL returns product[XLEN-1:0]; the other funcs return product[2*XLEN-1:XLEN].
- Accept: issue_valid && mult_free && !squash loads stage 0 at the next edge. issue_valid while mult_free==0 is a protocol error; Issue must never do it.
- mult_cdb_req = valid[STAGES-2] && !squash.
- stall = valid[STAGES-2] && !mult_cdb_gnt.
  - No stall: every stage advances by one.
  - Stall: stages 0..STAGES-2 hold and stage STAGES-1 is cleared; mult_free = !stall.
- Stage STAGES-1 is loaded only on grant, so out_valid is always a one-cycle pulse.
- Latency with no stalls: issue at edge t, broadcast during cycle t+STAGES. Throughput is 1 per cycle.
- A granted op is broadcast exactly once. A grant with mult_cdb_req==0 is ignored.
- Squash:
  - At the next edge all valid bits and out_valid clear.
  - Same-cycle issue is dropped.
  - Same-cycle grant is wasted; the result is not broadcast.
  - Squash takes priority over every other event.
- Reset mid-stall returns to the idle state immediately; no pending req survives.
- Data fields of invalid stages are don't-care. out_result/out_dest_prn hold their last value when out_valid==0.

Optional Feature:
- MULT_BUBBLE_COLLAPSE_EN defined: on a stall, stage k (k < STAGES-2) advances into k+1 if stage k+1 is empty or itself advancing. Evaluation runs top-down from stage STAGES-3.
- mult_free = !valid[0] || stage 0 advancing, so bubbles are squeezed out while the head waits for a grant.
- Undefined: full freeze as above.
- Grant, squash and output behaviour are identical in both builds.

Decomposition:
- sys_defs package:
  - MULT_FUNC enum (MUL, MULH, MULHSU, MULHU).
  - MULT_STAGE_PACKET struct (valid, func, dest_prn, mcand, mplier, sum).
  - `MULT_STAGES default.
- Sub-module mult_stage: one combinational partial-product step (mcand, mplier chunk, sum -> next packet). It is instantiated STAGES times, with the registers held in mult_fu.

Test Plan:
- Single op: MUL 7*6 with gnt tied high, dest_prn=5 -> mult_cdb_req at cycle t+3, out_valid at t+4 with result 42 and tag 5.
- Func coverage:
  - MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000.
  - MULHU same operands -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
  - MUL 0x80000000*2 -> 0x00000000.
- Stall: 4 back-to-back issues with gnt held low for 3 cycles -> mult_free=0 throughout the stall, req held, no out_valid. After gnt rises, results come out in issue order on consecutive cycles with none lost or duplicated.
- Squash with ops in stages 0,1,2, squash, gnt and issue_valid all in the same cycle -> no out_valid at any later cycle, req=0 and mult_free=1 next cycle.
- Async reset (reset=0) asserted mid-pipeline between clock edges -> outputs clear immediately, without waiting for an edge. The first issue after release gives a correct result at +STAGES.
- With MULT_BUBBLE_COLLAPSE_EN: ops in stages 0 and 2 only, gnt low -> the stage-0 op advances to stage 1 and mult_free=1 for one cycle; without the macro, mult_free=0.
